// File: rtl/rv32_mem_arbiter.sv
// ---------------------------------------------------------------------------
// rv32_mem_arbiter
//
// Shares one synchronous memory port between the instruction-fetch (IF) and
// data load/store (D) requesters of the rv32 core. One transaction is in
// flight at a time; contention is broken round-robin on the last owner.
//
// Handshake: a requester raises *_req together with its command and holds
// both until it sees a one-cycle *_gnt pulse; the command is latched when the
// grant is decided, so the requester may change or drop req from the grant
// cycle onward. Completion is a one-cycle *_rvalid pulse with *_rdata
// (0 for a D write acknowledge). Requests are only looked at in IDLE.
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   if_req/if_addr             IF request and word address
//   if_gnt/if_rvalid/if_rdata  IF grant pulse, completion pulse, read data
//   d_req/d_we/d_be/d_addr/d_wdata   D request and command
//   d_gnt/d_rvalid/d_rdata     D grant pulse, completion pulse, read data
//   mem_en/mem_we/mem_be/mem_addr/mem_wdata   memory command (registered)
//   mem_rdata                  memory read data, MEM_LATENCY cycles after mem_en
//   dbg_state                  current FSM state for observation
//
// MEM_LATENCY must lie in 1..15 (4-bit wait counter).
// ---------------------------------------------------------------------------
module rv32_mem_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_gnt,
    output logic                    if_rvalid,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    output logic                    d_gnt,
    output logic                    d_rvalid,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic [1:0]              dbg_state
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic       owner_d;       // 1 = D owns the transaction, 0 = IF
    logic       last_owner_d;  // owner of the last completed transaction
    logic [3:0] lat_cnt;
    logic       any_req;
    logic       pick_d;

    assign any_req   = if_req | d_req;
    // D wins when alone, or on contention when IF was served last.
    assign pick_d    = d_req & (~if_req | ~last_owner_d);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (any_req) state_nx = S_ACCESS;
            S_ACCESS: state_nx = S_WAIT;
            S_WAIT:   if (lat_cnt == 4'd0) state_nx = S_RESP;
            S_RESP:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // All outputs come straight from flops. Grant and mem_en are set on the
    // IDLE->ACCESS edge so they are high exactly during ACCESS; rvalid is set
    // on the WAIT->RESP edge so it is high exactly during RESP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_d      <= 1'b0;
            last_owner_d <= 1'b0;
            lat_cnt      <= 4'd0;
            if_gnt       <= 1'b0;
            d_gnt        <= 1'b0;
            if_rvalid    <= 1'b0;
            d_rvalid     <= 1'b0;
            if_rdata     <= '0;
            d_rdata      <= '0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_be       <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
        end else begin
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            mem_en    <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        owner_d   <= pick_d;
                        if_gnt    <= ~pick_d;
                        d_gnt     <= pick_d;
                        mem_en    <= 1'b1;
                        mem_we    <= pick_d ? d_we    : 1'b0;
                        mem_be    <= pick_d ? d_be    : {BE_WIDTH{1'b1}};
                        mem_addr  <= pick_d ? d_addr  : if_addr;
                        mem_wdata <= pick_d ? d_wdata : '0;
                    end
                end
                S_ACCESS: begin
                    lat_cnt <= 4'(MEM_LATENCY - 1);
                end
                S_WAIT: begin
                    if (lat_cnt == 4'd0) begin
                        if (owner_d) begin
                            d_rdata  <= mem_we ? '0 : mem_rdata;
                            d_rvalid <= 1'b1;
                        end else begin
                            if_rdata  <= mem_rdata;
                            if_rvalid <= 1'b1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    last_owner_d <= owner_d;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// ---------------------------------------------------------------------------
// Bench for rv32_mem_arbiter. dut1 runs with MEM_LATENCY=1 and carries most
// scenarios; dut4 runs with MEM_LATENCY=4 for the long-latency read.
// Each memory model returns data_of(addr) only in the cycle exactly
// MEM_LATENCY cycles after mem_en and a junk pattern in every other cycle.
// ---------------------------------------------------------------------------
module tb_rv32_mem_arbiter;

    localparam int LAT1 = 1;
    localparam int LAT4 = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // dut1 signals
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_be = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [1:0]  dbg_state;

    // dut4 signals
    logic        if_req4 = 1'b0;
    logic [31:0] if_addr4 = '0;
    logic        if_gnt4, if_rvalid4;
    logic [31:0] if_rdata4;
    logic        d_gnt4, d_rvalid4;
    logic [31:0] d_rdata4;
    logic        mem_en4, mem_we4;
    logic [3:0]  mem_be4;
    logic [31:0] mem_addr4, mem_wdata4;
    logic [31:0] mem_rdata4 = '0;
    logic [1:0]  dbg_state4;

    rv32_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(LAT1)) dut1 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    rv32_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(LAT4)) dut4 (
        .clk(clk), .reset(reset),
        .if_req(if_req4), .if_addr(if_addr4), .if_gnt(if_gnt4),
        .if_rvalid(if_rvalid4), .if_rdata(if_rdata4),
        .d_req(1'b0), .d_we(1'b0), .d_be(4'h0), .d_addr(32'h0), .d_wdata(32'h0),
        .d_gnt(d_gnt4), .d_rvalid(d_rvalid4), .d_rdata(d_rdata4),
        .mem_en(mem_en4), .mem_we(mem_we4), .mem_be(mem_be4), .mem_addr(mem_addr4),
        .mem_wdata(mem_wdata4), .mem_rdata(mem_rdata4), .dbg_state(dbg_state4)
    );

    function automatic logic [31:0] data_of(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory models: command seen in cycle c is answered in cycle c+LAT.
    logic [32:0] pipe1[16];
    logic [32:0] pipe4[16];
    initial begin
        for (int i = 0; i < 16; i++) begin
            pipe1[i] = '0;
            pipe4[i] = '0;
        end
    end
    always @(negedge clk) begin
        for (int i = 15; i > 0; i--) begin
            pipe1[i] = pipe1[i-1];
            pipe4[i] = pipe4[i-1];
        end
        pipe1[0] = {mem_en, mem_addr};
        pipe4[0] = {mem_en4, mem_addr4};
        mem_rdata  = pipe1[LAT1][32] ? data_of(pipe1[LAT1][31:0]) : 32'hBAD0BAD0;
        mem_rdata4 = pipe4[LAT4][32] ? data_of(pipe4[LAT4][31:0]) : 32'hBAD4BAD4;
    end

    // Scoreboard state for dut1
    logic [31:0] if_exp_q[$];
    logic [31:0] d_exp_q[$];
    logic [68:0] if_cmd_q[$];
    logic [68:0] d_cmd_q[$];
    logic        gnt_own_q[$];
    int          gnt_cyc_q[$];
    int          if_gnt_cyc = 0;
    int          d_gnt_cyc = 0;

    // Monitor for dut1: grants, memory commands and completions.
    always @(negedge clk) begin
        logic [68:0] got;
        logic [68:0] c;
        logic [31:0] e;
        if (reset) begin
            if (if_gnt || d_gnt) begin
                total++;
                if (if_gnt && d_gnt) begin
                    bad++;
                    $display("FAIL gnt_exclusive if_gnt=%b d_gnt=%b need one", if_gnt, d_gnt);
                end
                total++;
                if (mem_en !== 1'b1) begin
                    bad++;
                    $display("FAIL gnt_with_mem_en mem_en=%b need 1", mem_en);
                end
                gnt_own_q.push_back(d_gnt);
                gnt_cyc_q.push_back(cyc);
                if (if_gnt) if_gnt_cyc = cyc;
                if (d_gnt) d_gnt_cyc = cyc;
            end
            if (mem_en) begin
                got = {mem_we, mem_be, mem_addr, mem_wdata};
                total++;
                if (d_gnt && !if_gnt && d_cmd_q.size() > 0) begin
                    c = d_cmd_q.pop_front();
                    if (got !== c) begin
                        bad++;
                        $display("FAIL d_mem_cmd got=%h need=%h", got, c);
                    end
                end else if (if_gnt && !d_gnt && if_cmd_q.size() > 0) begin
                    c = if_cmd_q.pop_front();
                    if (got !== c) begin
                        bad++;
                        $display("FAIL if_mem_cmd got=%h need=%h", got, c);
                    end
                end else begin
                    bad++;
                    $display("FAIL mem_en_orphan if_gnt=%b d_gnt=%b need a single pending grant", if_gnt, d_gnt);
                end
            end
            if (if_rvalid && d_rvalid) begin
                total++;
                bad++;
                $display("FAIL rvalid_exclusive both=1 need one");
            end
            if (if_rvalid) begin
                total++;
                if (if_exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL if_rvalid_unexpected rdata=%h need no rvalid", if_rdata);
                end else begin
                    e = if_exp_q.pop_front();
                    if (if_rdata !== e) begin
                        bad++;
                        $display("FAIL if_rdata got=%h need=%h", if_rdata, e);
                    end
                    total++;
                    if (cyc - if_gnt_cyc != LAT1 + 1) begin
                        bad++;
                        $display("FAIL if_latency got=%0d need=%0d", cyc - if_gnt_cyc, LAT1 + 1);
                    end
                end
            end
            if (d_rvalid) begin
                total++;
                if (d_exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL d_rvalid_unexpected rdata=%h need no rvalid", d_rdata);
                end else begin
                    e = d_exp_q.pop_front();
                    if (d_rdata !== e) begin
                        bad++;
                        $display("FAIL d_rdata got=%h need=%h", d_rdata, e);
                    end
                    total++;
                    if (cyc - d_gnt_cyc != LAT1 + 1) begin
                        bad++;
                        $display("FAIL d_latency got=%0d need=%0d", cyc - d_gnt_cyc, LAT1 + 1);
                    end
                end
            end
        end
    end

    // Driver tasks: called at a negedge, return at the negedge the grant is seen.
    task automatic issue_if(input logic [31:0] a, output int gc);
        if_exp_q.push_back(data_of(a));
        if_cmd_q.push_back({1'b0, 4'hF, a, 32'h0});
        if_req  = 1'b1;
        if_addr = a;
        gc = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (if_gnt) begin
                gc = cyc;
                break;
            end
        end
        if_req = 1'b0;
        if (gc < 0) begin
            total++;
            bad++;
            $display("FAIL if_gnt_timeout addr=%h got no grant need grant", a);
        end
    endtask

    task automatic issue_d(input logic we, input logic [3:0] be, input logic [31:0] a,
                           input logic [31:0] wd, output int gc);
        d_exp_q.push_back(we ? 32'h0 : data_of(a));
        d_cmd_q.push_back({we, be, a, wd});
        d_req   = 1'b1;
        d_we    = we;
        d_be    = be;
        d_addr  = a;
        d_wdata = wd;
        gc = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (d_gnt) begin
                gc = cyc;
                break;
            end
        end
        d_req = 1'b0;
        if (gc < 0) begin
            total++;
            bad++;
            $display("FAIL d_gnt_timeout addr=%h got no grant need grant", a);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100; i++) begin
            if (if_exp_q.size() == 0 && d_exp_q.size() == 0) break;
            @(negedge clk);
        end
        total++;
        if (if_exp_q.size() != 0 || d_exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout pending if=%0d d=%0d need 0", if_exp_q.size(), d_exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        int rel, gd, gi;
        logic [188:0] outs;
        reset = 1'b1;
        #1 reset = 1'b0;
        if_req = 1'b1;  if_addr = 32'h44;
        d_req  = 1'b1;  d_addr  = 32'h40; d_we = 1'b0; d_be = 4'hF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            outs = {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, mem_be,
                    mem_addr, mem_wdata, if_rdata, d_rdata};
            total++;
            if (outs !== '0) begin
                bad++;
                $display("FAIL reset_outputs got=%h need 0", outs);
            end
        end
        rel = cyc;
        fork
            reset = 1'b1;
            issue_d(1'b0, 4'hF, 32'h40, 32'h0, gd);
            issue_if(32'h44, gi);
        join
        total++;
        if (gd - rel != 1) begin
            bad++;
            $display("FAIL first_contention_d got d_gnt cycle %0d need 1", gd - rel);
        end
        total++;
        if (gi - rel != LAT1 + 4) begin
            bad++;
            $display("FAIL second_grant_if got if_gnt cycle %0d need %0d", gi - rel, LAT1 + 4);
        end
        wait_drain();
    endtask

    task automatic test_single_if_read();
        int g;
        issue_if(32'h100, g);
        wait_drain();
        total++;
        if (if_rdata !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL if_rdata_hold got=%h need=%h", if_rdata, 32'hDEADBEEF);
        end
    endtask

    task automatic test_back_to_back();
        int n0;
        n0 = gnt_own_q.size();
        fork
            begin
                int g;
                for (int k = 0; k < 3; k++) issue_d(1'b0, 4'hF, 32'h80 + 32'(k * 4), 32'h0, g);
            end
            begin
                int g;
                for (int k = 0; k < 3; k++) issue_if(32'h180 + 32'(k * 4), g);
            end
        join
        wait_drain();
        total++;
        if (gnt_own_q.size() - n0 != 6) begin
            bad++;
            $display("FAIL b2b_count got=%0d need 6", gnt_own_q.size() - n0);
        end else begin
            for (int k = 0; k < 6; k++) begin
                total++;
                if (gnt_own_q[n0 + k] !== ((k % 2) == 0)) begin
                    bad++;
                    $display("FAIL b2b_owner idx=%0d got d=%b need d=%b", k, gnt_own_q[n0 + k], (k % 2) == 0);
                end
                if (k > 0) begin
                    total++;
                    if (gnt_cyc_q[n0 + k] - gnt_cyc_q[n0 + k - 1] != LAT1 + 3) begin
                        bad++;
                        $display("FAIL b2b_spacing idx=%0d got=%0d need=%0d", k,
                                 gnt_cyc_q[n0 + k] - gnt_cyc_q[n0 + k - 1], LAT1 + 3);
                    end
                end
            end
        end
    endtask

    task automatic test_d_write();
        int g;
        issue_d(1'b0, 4'hF, 32'h2C0, 32'h0, g);
        wait_drain();
        issue_d(1'b1, 4'h3, 32'h200, 32'h1234, g);
        wait_drain();
        total++;
        if (d_rdata !== 32'h0) begin
            bad++;
            $display("FAIL d_write_rdata got=%h need 0", d_rdata);
        end
    endtask

    task automatic test_reset_in_wait();
        int g, n;
        logic [188:0] outs;
        issue_if(32'h300, g);
        @(negedge clk);
        reset = 1'b0;
        if_exp_q.delete();
        #1;
        outs = {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, mem_be,
                mem_addr, mem_wdata, if_rdata, d_rdata};
        total++;
        if (outs !== '0) begin
            bad++;
            $display("FAIL reset_in_wait_outputs got=%h need 0", outs);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (if_rvalid || d_rvalid) n++;
        end
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL reset_in_wait_rvalid got=%0d need 0", n);
        end
        issue_if(32'h304, g);
        wait_drain();
        total++;
        if (if_rdata !== data_of(32'h304)) begin
            bad++;
            $display("FAIL post_reset_read got=%h need=%h", if_rdata, data_of(32'h304));
        end
    endtask

    task automatic test_latency4();
        int g, r;
        g = -1;
        r = -1;
        if_req4  = 1'b1;
        if_addr4 = 32'h400;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (if_gnt4) begin
                g = cyc;
                break;
            end
        end
        total++;
        if (g < 0 || mem_en4 !== 1'b1 || mem_addr4 !== 32'h400 || mem_be4 !== 4'hF || mem_we4 !== 1'b0) begin
            bad++;
            $display("FAIL lat4_access gnt=%0d en=%b addr=%h be=%h we=%b need en=1 addr=400 be=f we=0",
                     g, mem_en4, mem_addr4, mem_be4, mem_we4);
        end
        if_req4 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (if_rvalid4) begin
                r = cyc;
                break;
            end
        end
        total++;
        if (r < 0 || r - g != LAT4 + 1) begin
            bad++;
            $display("FAIL lat4_rvalid_cycle got=%0d need=%0d", r - g, LAT4 + 1);
        end
        total++;
        if (if_rdata4 !== data_of(32'h400)) begin
            bad++;
            $display("FAIL lat4_rdata got=%h need=%h", if_rdata4, data_of(32'h400));
        end
    endtask

    initial begin
        test_reset();
        test_single_if_read();
        test_back_to_back();
        test_d_write();
        test_reset_in_wait();
        test_latency4();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv32_mem_arbiter.md
# rv32_mem_arbiter

Two-port arbiter that shares a single synchronous memory port between the instruction-fetch (IF) and data load/store (D) requesters of the rv32 core inside rv32_soc. It serialises accesses with a req/gnt/rvalid handshake, allows one outstanding transaction, breaks contention round-robin, and returns read data (or a write acknowledge) to the requester that owned the transaction.

## Interface
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8 bits
- MEM_LATENCY, 1, cycles from mem_en to valid mem_rdata; legal range 1..15
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low reset (reset=0 clears all state immediately)
- if_req  input  1  IF request; held with if_addr until if_gnt
- if_addr  input  ADDR_WIDTH  IF word address
- if_gnt  output  1  one-cycle grant pulse to IF
- if_rvalid  output  1  one-cycle IF read-data valid
- if_rdata  output  DATA_WIDTH  IF read data
- d_req  input  1  data request; held with d_we/d_be/d_addr/d_wdata until d_gnt
- d_we  input  1  1 = write, 0 = read
- d_be  input  DATA_WIDTH/8  write byte enables
- d_addr  input  ADDR_WIDTH  data address
- d_wdata  input  DATA_WIDTH  write data
- d_gnt  output  1  one-cycle grant pulse to D
- d_rvalid  output  1  one-cycle completion (read data or write ack)
- d_rdata  output  DATA_WIDTH  data read result; 0 on write completion
- mem_en  output  1  memory access strobe, one cycle per transaction
- mem_we, mem_be, mem_addr, mem_wdata  output  1 / DATA_WIDTH/8 / ADDR_WIDTH / DATA_WIDTH  memory command
- mem_rdata  input  DATA_WIDTH  memory read data, valid MEM_LATENCY cycles after mem_en

## Operation
- FSM states IDLE, ACCESS, WAIT, RESP; reset state IDLE.
- IDLE: if neither req, stay. Otherwise pick winner, latch its command into mem_* registers, set owner, pulse winner's gnt, raise mem_en, go to ACCESS.
- Arbitration: single requester wins. Both requesting: grant the one not granted last (last_owner register). last_owner resets to IF, so the first contention goes to D.
- IF commands: mem_we=0, mem_be=all ones, mem_wdata=0.
- ACCESS: mem_en=1, gnt=1 (both for exactly this cycle); load counter with MEM_LATENCY-1; go to WAIT.
- WAIT: when counter=0 capture mem_rdata (forced to 0 if write) into owner's rdata register, go to RESP; else decrement.
- RESP: owner's rvalid=1 for one cycle; update last_owner=owner; go to IDLE.
- Requests are sampled only in IDLE; req arriving in any other state waits. Dropping req before gnt is a protocol violation (behaviour unspecified).
- Reset asserted mid-transaction: state to IDLE, all outputs to reset values, transaction dropped, no rvalid issued.
- Reset values: if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we = 0; mem_be, mem_addr, mem_wdata, if_rdata, d_rdata = 0.
- mem_addr/be/we/wdata hold their value until the next ACCESS; rdata outputs hold until overwritten by next completion for that port.

## Timing
- Cycle 0 = IDLE cycle with req high. Cycle 1: gnt=1, mem_en=1. Memory data valid cycle 1+MEM_LATENCY. Cycle 2+MEM_LATENCY: rvalid=1 with rdata.
- Next arbitration cycle 3+MEM_LATENCY; next earliest gnt 4+MEM_LATENCY. Throughput: one transaction per MEM_LATENCY+3 cycles.
- All outputs registered; no combinational path from any input to any output.
- if_gnt and d_gnt never high in the same cycle; same for if_rvalid/d_rvalid.

## Test plan
- Reset: hold reset=0 with both reqs high -> all outputs 0, no gnt; release -> D granted first (d_gnt in cycle 1).
- Single IF read, MEM_LATENCY=1, if_addr=0x100, mem model returns 0xDEADBEEF -> if_gnt cycle 1, mem_en cycle 1 with mem_addr=0x100, mem_be=0xF, if_rvalid cycle 3 with if_rdata=0xDEADBEEF.
- D write d_addr=0x200, d_be=0x3, d_wdata=0x1234 -> mem_we=1, mem_be=0x3, mem_wdata=0x1234 in ACCESS; d_rvalid with d_rdata=0.
- Both reqs held continuously for 6 transactions -> grants alternate D,IF,D,IF,D,IF; gnt spacing MEM_LATENCY+3 cycles.
- MEM_LATENCY=4 IF read -> rvalid in cycle 6 carrying data presented in cycle 5 only.
- Reset asserted in WAIT -> immediate return to IDLE, no rvalid; next request completes normally.
